// File: rtl/upload_pkg.sv
// Shared definitions for the upload channel rotator: default sizes,
// a minimum-one clog2 helper and the channel index type.
package upload_pkg;

    localparam int DEF_DATA_W    = 64;
    localparam int DEF_FRAME_LEN = 512;
    localparam int MAX_CH        = 8;

    // Bit width needed to index 'value' items, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    typedef logic [clog2_min1(MAX_CH)-1:0] ch_idx_t;

endpackage

// File: rtl/upload_frame_counter.sv
// Beat counter for the frame currently being uploaded. Flags the last beat
// (wrap) combinationally so the top can advance the output pointer on the
// same edge. Optional macro UPLOAD_ROTATOR_FRAME_TAG_EN adds registered
// start/end-of-frame strobes aligned with the registered data valid.
module upload_frame_counter
    import upload_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic beat,
    output logic wrap
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
    ,
    output logic frame_sof,
    output logic frame_eof
`endif
);

    localparam int CNT_W = clog2_min1(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] beat_cnt;

    assign wrap = beat & (beat_cnt == LAST_BEAT);

    // Count accepted beats, restarting after the last beat of each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= wrap ? '0 : beat_cnt + CNT_W'(1);
        end
    end

`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
    // Frame boundary strobes, registered to line up with data_valid_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sof <= 1'b0;
            frame_eof <= 1'b0;
        end else begin
            frame_sof <= beat & (beat_cnt == '0);
            frame_eof <= wrap;
        end
    end
`endif

endmodule

// File: rtl/upload_channel_rotator.sv
// Round-robin trigger distributor and in-order upload mux for N_CH
// processing channels. Triggers are dropped (and counted) while every
// channel holds an outstanding frame. The output channel only changes on a
// frame boundary. Optional macro UPLOAD_ROTATOR_FRAME_TAG_EN adds
// frame_sof / frame_eof / frame_ch tag outputs.
module upload_channel_rotator
    import upload_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int DROP_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trigger_start,
    input  logic                   Upload_En,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic [N_CH-1:0]        data_valid_i,
    output logic [N_CH-1:0]        trigger_start_o,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_valid_o,
    output logic                   busy,
    output logic [DROP_CNT_W-1:0]  drop_cnt
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
    ,
    output logic                   frame_sof,
    output logic                   frame_eof,
    output logic [$clog2(N_CH)-1:0] frame_ch
`endif
);

    localparam int PTR_W  = clog2_min1(N_CH);
    localparam int PEND_W = $clog2(N_CH + 1);

    logic [PTR_W-1:0]  trig_ptr;
    logic [PTR_W-1:0]  out_ptr;
    logic [PEND_W-1:0] pending;
    logic              has_pending;
    logic              sel_valid;
    logic              frame_done;
    logic              accept;
    logic              reject;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(N_CH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign has_pending = (pending != '0);
    assign sel_valid   = data_valid_i[out_ptr] & has_pending;
    // Occupancy is judged before any same-cycle frame completion.
    assign accept      = trigger_start & Upload_En & (pending < PEND_W'(N_CH));
    assign reject      = trigger_start & Upload_En & (pending == PEND_W'(N_CH));
    assign busy        = has_pending;

    upload_frame_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_frame_counter (
        .clk       (clk),
        .rst       (rst),
        .beat      (sel_valid),
        .wrap      (frame_done)
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
        ,
        .frame_sof (frame_sof),
        .frame_eof (frame_eof)
`endif
    );

    // Trigger/output pointers and outstanding-frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_ptr <= '0;
            out_ptr  <= '0;
            pending  <= '0;
        end else begin
            if (accept) begin
                trig_ptr <= ptr_inc(trig_ptr);
            end
            if (frame_done) begin
                out_ptr <= ptr_inc(out_ptr);
            end
            if (accept && !frame_done) begin
                pending <= pending + PEND_W'(1);
            end else if (!accept && frame_done) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

    // One-hot trigger pulse and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_start_o <= '0;
            drop_cnt        <= '0;
        end else begin
            trigger_start_o <= accept ? (N_CH'(1) << trig_ptr) : '0;
            if (reject && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

    // Registered output mux; data follows out_ptr every cycle, valid only
    // while a frame is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= '0;
            data_valid_o <= 1'b0;
        end else begin
            data_out     <= data_in[int'(out_ptr)*DATA_W +: DATA_W];
            data_valid_o <= sel_valid;
        end
    end

`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
    // Channel tag for the frame on the output, aligned with data_valid_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ch <= '0;
        end else begin
            frame_ch <= ($clog2(N_CH))'(out_ptr);
        end
    end
`endif

endmodule

// File: tb/tb_upload_channel_rotator.sv
// Self-checking bench for upload_channel_rotator (N_CH=4, FRAME_LEN=4).
// A frame-level model (issued/completed frame counts) predicts every
// registered output each cycle; directed literal checks pin the model.
module tb_upload_channel_rotator;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int FL   = 4;
    localparam int DRW  = 3;
    localparam int DMAX = (1 << DRW) - 1;

    logic            clk;
    logic            rst;
    logic            trigger_start;
    logic            Upload_En;
    logic [N*DW-1:0] data_in;
    logic [N-1:0]    data_valid_i;
    logic [N-1:0]    trigger_start_o;
    logic [DW-1:0]   data_out;
    logic            data_valid_o;
    logic            busy;
    logic [DRW-1:0]  drop_cnt;
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
    logic            frame_sof;
    logic            frame_eof;
    logic [1:0]      frame_ch;
`endif

    upload_channel_rotator #(
        .N_CH       (N),
        .DATA_W     (DW),
        .FRAME_LEN  (FL),
        .DROP_CNT_W (DRW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trigger_start   (trigger_start),
        .Upload_En       (Upload_En),
        .data_in         (data_in),
        .data_valid_i    (data_valid_i),
        .trigger_start_o (trigger_start_o),
        .data_out        (data_out),
        .data_valid_o    (data_valid_o),
        .busy            (busy),
        .drop_cnt        (drop_cnt)
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
        ,
        .frame_sof       (frame_sof),
        .frame_eof       (frame_eof),
        .frame_ch        (frame_ch)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: frames issued and completed since reset.
    int   issued, completed, beats, drops;
    bit   ready = 0;
    logic [N-1:0]  exp_trig;
    logic [DW-1:0] exp_data;
    logic          exp_valid, exp_busy, exp_sof, exp_eof;
    logic [DRW-1:0] exp_drop;
    int            exp_ch;

    always @(posedge clk) begin
        int  pend, oc, tc;
        bit  done, acc, rej;
        if (rst) begin
            issued = 0; completed = 0; beats = 0; drops = 0;
            exp_trig = '0; exp_data = '0; exp_valid = 0; exp_busy = 0;
            exp_drop = '0; exp_sof = 0; exp_eof = 0; exp_ch = 0;
            ready = 1;
        end else begin
            pend      = issued - completed;
            oc        = completed % N;
            tc        = issued % N;
            exp_data  = data_in[oc*DW +: DW];
            exp_valid = data_valid_i[oc] && (pend > 0);
            done      = exp_valid && (beats == FL - 1);
            exp_sof   = exp_valid && (beats == 0);
            exp_eof   = done;
            exp_ch    = oc;
            acc       = trigger_start && Upload_En && (pend < N);
            rej       = trigger_start && Upload_En && (pend == N);
            exp_trig  = acc ? N'(1 << tc) : '0;
            if (exp_valid) beats = done ? 0 : beats + 1;
            if (done) completed++;
            if (acc) issued++;
            if (rej && drops < DMAX) drops++;
            exp_busy  = (issued != completed);
            exp_drop  = DRW'(drops);
        end
    end

    // Compare every registered output against the model each cycle.
    always @(posedge clk) begin
        #1;
        if (ready) begin
            chk("model trigger_start_o", 32'(trigger_start_o), 32'(exp_trig));
            chk("model data_out",        32'(data_out),        32'(exp_data));
            chk("model data_valid_o",    32'(data_valid_o),    32'(exp_valid));
            chk("model busy",            32'(busy),            32'(exp_busy));
            chk("model drop_cnt",        32'(drop_cnt),        32'(exp_drop));
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
            chk("model frame_sof", 32'(frame_sof), 32'(exp_sof));
            chk("model frame_eof", 32'(frame_eof), 32'(exp_eof));
            if (exp_valid) chk("model frame_ch", 32'(frame_ch), 32'(exp_ch));
`endif
        end
    end

    // Drive one cycle of inputs at negedge; return just after the next posedge.
    task automatic step(input logic ts, input logic en, input logic [N-1:0] dv);
        @(negedge clk);
        cyc++;
        trigger_start = ts;
        Upload_En     = en;
        data_valid_i  = dv;
        for (int k = 0; k < N; k++) data_in[k*DW +: DW] = {4'(k), 12'(cyc)};
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; trigger_start = 0; Upload_En = 0; data_valid_i = '0;
        data_in = {N*DW{1'b1}};
        step(1, 1, 4'b1111);
        step(0, 1, 4'b1111);
        chk("reset trigger_start_o", 32'(trigger_start_o), 0);
        chk("reset data_out",        32'(data_out), 0);
        chk("reset data_valid_o",    32'(data_valid_o), 0);
        chk("reset busy",            32'(busy), 0);
        chk("reset drop_cnt",        32'(drop_cnt), 0);
        rst = 1'b0;

        // ch1 valid while nothing pending / pointer on ch0 is ignored
        step(0, 1, 4'b0010);
        chk("idle valid ignored", 32'(data_valid_o), 0);
        step(0, 1, 4'b0010);
        step(1, 1, 4'b0000);
        chk("first trigger ch0", 32'(trigger_start_o), 32'h1);
        step(1, 1, 4'b0010);
        chk("second trigger ch1", 32'(trigger_start_o), 32'h2);
        chk("busy after triggers", 32'(busy), 1);
        step(0, 1, 4'b0010);
        chk("ch1 beat while out ch0", 32'(data_valid_o), 0);
        for (int i = 0; i < FL; i++) step(0, 1, 4'b0001);
        chk("ch0 last beat valid", 32'(data_valid_o), 1);
        chk("ch0 last beat data", 32'(data_out), 32'({4'd0, 12'(cyc)}));
        for (int i = 0; i < FL; i++) step(0, 1, 4'b0010);
        chk("ch1 last beat data", 32'(data_out), 32'({4'd1, 12'(cyc)}));
        chk("idle after two frames", 32'(busy), 0);

        // six triggers, no data: four issued (ch2,ch3,ch0,ch1), two dropped
        step(1, 1, 4'b0000);
        chk("wrapped trigger ch2", 32'(trigger_start_o), 32'h4);
        for (int i = 0; i < 5; i++) step(1, 1, 4'b0000);
        chk("drop count two", 32'(drop_cnt), 2);
        chk("no trigger when full", 32'(trigger_start_o), 0);

        // trigger on last beat with all channels pending: rejected
        for (int i = 0; i < FL - 1; i++) step(0, 1, 4'b0100);
        step(1, 1, 4'b0100);
        chk("full at frame end rejects", 32'(trigger_start_o), 0);
        chk("drop count three", 32'(drop_cnt), 3);
        for (int i = 0; i < FL; i++) step(0, 1, 4'b1000);
        for (int i = 0; i < FL; i++) step(0, 1, 4'b0001);
        // one pending: trigger on last beat is accepted, pending stays 1
        for (int i = 0; i < FL - 1; i++) step(0, 1, 4'b0010);
        step(1, 1, 4'b0010);
        chk("accept on frame end", 32'(trigger_start_o), 32'h4);
        chk("busy after swap", 32'(busy), 1);

        // Upload_En low: triggers ignored, in-flight ch2 frame completes
        for (int i = 0; i < 10; i++) begin
            step(1, 0, (i < FL) ? 4'b0100 : 4'b0000);
            chk("disabled no trigger", 32'(trigger_start_o), 0);
        end
        chk("disabled drop unchanged", 32'(drop_cnt), 3);
        chk("in-flight frame done", 32'(busy), 0);

        // reset mid-frame
        step(1, 1, 4'b0000);
        chk("trigger ch3", 32'(trigger_start_o), 32'h8);
        step(0, 1, 4'b1000);
        step(0, 1, 4'b1000);
        rst = 1'b1;
        step(1, 1, 4'b1000);
        chk("mid reset data_out",     32'(data_out), 0);
        chk("mid reset data_valid_o", 32'(data_valid_o), 0);
        chk("mid reset busy",         32'(busy), 0);
        chk("mid reset drop_cnt",     32'(drop_cnt), 0);
        rst = 1'b0;
        step(1, 1, 4'b0000);
        chk("post reset trigger ch0", 32'(trigger_start_o), 32'h1);
        step(0, 1, 4'b0001);
        chk("post reset first beat", 32'(data_valid_o), 1);
`ifdef UPLOAD_ROTATOR_FRAME_TAG_EN
        chk("post reset sof", 32'(frame_sof), 1);
`endif

        // drop counter saturation: 3 accepts then 9 rejects
        for (int i = 0; i < 12; i++) step(1, 1, 4'b0000);
        chk("drop saturates", 32'(drop_cnt), DMAX);
        step(0, 1, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
